// File: rtl/matmul_sequencer.sv
// matmul_sequencer: schedules one 4x4 systolic matmul job over K-tiles.
// Each tile is one CLEAR cycle followed by a RUN pass of count 0..LAST_COUNT.
// The count/shouldAdd pair feeds the diagonal drain dispatcher, and
// array_clear/feed_en strobe the PE array. A stall freezes the RUN pass.
module matmul_sequencer #(
    parameter int COUNT_W     = 5,
    parameter int LAST_COUNT  = 11,
    parameter int FEED_LAST   = 6,
    parameter int DRAIN_FIRST = 5,
    parameter int TILE_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [TILE_W-1:0]  num_tiles,
    input  logic               acc_en,
    input  logic               stall,
    output logic [COUNT_W-1:0] count,
    output logic               shouldAdd,
    output logic               array_clear,
    output logic               feed_en,
    output logic               drain_valid,
    output logic [TILE_W-1:0]  tile_idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, FIN} state_t;

    state_t              state_reg, state_next;
    logic [COUNT_W-1:0]  count_reg, count_next;
    logic [TILE_W-1:0]   tile_idx_reg, tile_idx_next;
    logic [TILE_W-1:0]   num_tiles_reg, num_tiles_next;
    logic                acc_en_reg, acc_en_next;
    logic                should_add_reg, should_add_next;
    logic                array_clear_reg, done_reg, busy_reg;

    // Next-state and schedule decode; every target defaults to hold.
    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        tile_idx_next   = tile_idx_reg;
        num_tiles_next  = num_tiles_reg;
        acc_en_next     = acc_en_reg;
        should_add_next = should_add_reg;
        case (state_reg)
            IDLE: begin
                count_next      = '0;
                should_add_next = 1'b0;
                if (start) begin
                    if (num_tiles != '0) begin
                        state_next      = CLEAR;
                        num_tiles_next  = num_tiles;
                        acc_en_next     = acc_en;
                        tile_idx_next   = '0;
                        // First tile overwrites unless the job asked to accumulate.
                        should_add_next = acc_en;
                    end else begin
                        // Empty job: report completion without touching the array.
                        state_next = FIN;
                    end
                end
            end
            CLEAR: begin
                count_next = '0;
                state_next = RUN;
            end
            RUN: begin
                if (!stall) begin
                    if (count_reg == COUNT_W'(LAST_COUNT)) begin
                        count_next = '0;
                        if (tile_idx_reg == num_tiles_reg - TILE_W'(1)) begin
                            state_next = FIN;
                        end else begin
                            tile_idx_next   = tile_idx_reg + TILE_W'(1);
                            // Later tiles always add onto the previous partial sums.
                            should_add_next = 1'b1;
                            state_next      = CLEAR;
                        end
                    end else begin
                        count_next = count_reg + COUNT_W'(1);
                    end
                end
            end
            FIN: begin
                count_next      = '0;
                should_add_next = 1'b0;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and schedule registers; strobes registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            tile_idx_reg    <= '0;
            num_tiles_reg   <= '0;
            acc_en_reg      <= 1'b0;
            should_add_reg  <= 1'b0;
            array_clear_reg <= 1'b0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            tile_idx_reg    <= tile_idx_next;
            num_tiles_reg   <= num_tiles_next;
            acc_en_reg      <= acc_en_next;
            should_add_reg  <= should_add_next;
            array_clear_reg <= (state_next == CLEAR);
            done_reg        <= (state_next == FIN);
            busy_reg        <= (state_next != IDLE);
        end
    end

    // Feed and drain windows are gated by stall so a frozen count emits nothing new.
    always_comb begin
        feed_en     = (state_reg == RUN) && (count_reg <= COUNT_W'(FEED_LAST)) && !stall;
        drain_valid = (state_reg == RUN) && (count_reg >= COUNT_W'(DRAIN_FIRST))
                      && (count_reg <= COUNT_W'(LAST_COUNT)) && !stall;
    end

    assign count       = count_reg;
    assign shouldAdd   = should_add_reg;
    assign array_clear = array_clear_reg;
    assign tile_idx    = tile_idx_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: a slot-queue job model checked every
// cycle, directed jobs with literal latency/pulse counts, then random traffic.
module tb_matmul_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_tiles = 8'd0;
    logic       acc_en = 1'b0;
    logic       stall = 1'b0;
    logic [4:0] count;
    logic       shouldAdd, array_clear, feed_en, drain_valid, busy, done;
    logic [7:0] tile_idx;

    int checks = 0;
    int errors = 0;

    matmul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
        .acc_en(acc_en), .stall(stall), .count(count), .shouldAdd(shouldAdd),
        .array_clear(array_clear), .feed_en(feed_en), .drain_valid(drain_valid),
        .tile_idx(tile_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a job is a list of slots (CLEAR, RUN count c, FIN) per tile; a RUN slot
    // is held while stall is high, every other slot lasts exactly one cycle.
    typedef struct {
        int kind;   // 0 idle, 1 clear, 2 run, 3 fin
        int cnt;
        int tile;
        bit sa;
    } slot_t;

    slot_t       q[$];
    slot_t       h;
    logic [18:0] exp_v, act_v, msk;

    always @(negedge clk) begin
        act_v = {busy, done, array_clear, feed_en, drain_valid, shouldAdd, count, tile_idx};
        if (!rst_n) begin
            q.delete();
            checks++;
            if (act_v !== 19'd0) begin
                errors++;
                $display("FAIL reset_outs: got %h expected 0", act_v);
            end
        end else begin
            if (q.size() > 0) h = q[0];
            else h = '{kind: 0, cnt: 0, tile: 0, sa: 1'b0};
            exp_v = {h.kind != 0, h.kind == 3, h.kind == 1,
                     h.kind == 2 && h.cnt <= 6 && !stall,
                     h.kind == 2 && h.cnt >= 5 && !stall,
                     (h.kind == 1 || h.kind == 2) ? h.sa : 1'b0,
                     (h.kind == 2) ? 5'(h.cnt) : 5'd0,
                     8'(h.tile)};
            msk = 19'h7FFFF;
            if (!(h.kind == 1 || h.kind == 2)) msk[7:0] = 8'h00;
            if (h.kind == 3) msk[13] = 1'b0;
            checks++;
            if ((act_v & msk) !== (exp_v & msk)) begin
                errors++;
                $display("FAIL cycle_outs: got %h expected %h (mask %h) at %0t", act_v, exp_v, msk, $time);
            end
            // Advance the model by the edge that follows this sample.
            if (q.size() > 0) begin
                if (!(q[0].kind == 2 && stall)) void'(q.pop_front());
            end else if (start) begin
                for (int t = 0; t < int'(num_tiles); t++) begin
                    q.push_back('{kind: 1, cnt: 0, tile: t, sa: (t != 0) || acc_en});
                    for (int c = 0; c <= 11; c++)
                        q.push_back('{kind: 2, cnt: c, tile: t, sa: (t != 0) || acc_en});
                end
                q.push_back('{kind: 3, cnt: 0, tile: 0, sa: 1'b0});
            end
        end
    end

    // Runs one job; lat = edges from the accepting edge to done being visible.
    task automatic run_job(input int nt, input bit acc, input int stall_n, input bit poke,
                           output int lat, output int clears, output int drains,
                           output int busy_n, output logic [7:0] sa_bits);
        int  k;
        int  left;
        bit  got;
        @(posedge clk); #2;
        start = 1'b1; num_tiles = 8'(nt); acc_en = acc; stall = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        k = 0; left = stall_n; clears = 0; drains = 0; busy_n = 0; sa_bits = '0; got = 0; lat = -1;
        while (k < 2000) begin
            if (stall) begin
                left--;
                if (left == 0) stall = 1'b0;
            end else if (left > 0 && count == 5'd7) begin
                stall = 1'b1;
            end
            if (poke) start = (k == 5) || done;
            if (array_clear) begin
                if (clears < 8) sa_bits[clears] = shouldAdd;
                chk("clear_tile_idx", tile_idx, clears);
                clears++;
            end
            if (drain_valid) drains++;
            if (busy) busy_n++;
            if (done) begin
                lat = k; got = 1;
                break;
            end
            @(posedge clk); #2;
            k++;
        end
        if (!got) chk("job_timeout", 0, 1);
        @(posedge clk); #2;
        start = 1'b0;
        chk("idle_after_done", {busy, done}, 0);
    endtask

    int          lat, clr, drn, bsy;
    logic [7:0]  sab;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_busy_done", {busy, done, array_clear, shouldAdd}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // One tile, overwrite.
        run_job(1, 1'b0, 0, 1'b0, lat, clr, drn, bsy, sab);
        $display("job nt=1 acc=0: lat=%0d clears=%0d drains=%0d busy=%0d sa=%b", lat, clr, drn, bsy, sab[0]);
        chk("t1_latency", lat, 13);
        chk("t1_clears", clr, 1);
        chk("t1_drains", drn, 7);
        chk("t1_busy", bsy, 14);
        chk("t1_shouldadd", sab[0], 0);

        // Three tiles: shouldAdd 0,1,1.
        run_job(3, 1'b0, 0, 1'b0, lat, clr, drn, bsy, sab);
        $display("job nt=3 acc=0: lat=%0d clears=%0d drains=%0d sa=%b", lat, clr, drn, sab[2:0]);
        chk("t2_latency", lat, 39);
        chk("t2_clears", clr, 3);
        chk("t2_drains", drn, 21);
        chk("t2_shouldadd", sab[2:0], 3'b110);

        // Empty job.
        run_job(0, 1'b0, 0, 1'b0, lat, clr, drn, bsy, sab);
        $display("job nt=0: lat=%0d clears=%0d drains=%0d busy=%0d", lat, clr, drn, bsy);
        chk("t3_latency", lat, 0);
        chk("t3_clears", clr, 0);
        chk("t3_drains", drn, 0);
        chk("t3_busy", bsy, 1);

        // Three stall cycles at count 7.
        run_job(1, 1'b0, 3, 1'b0, lat, clr, drn, bsy, sab);
        $display("job nt=1 stall=3: lat=%0d drains=%0d busy=%0d", lat, drn, bsy);
        chk("t4_latency", lat, 16);
        chk("t4_drains", drn, 7);
        chk("t4_busy", bsy, 17);

        // Start pulses in RUN and FIN are ignored; acc_en makes both tiles add.
        run_job(2, 1'b1, 0, 1'b1, lat, clr, drn, bsy, sab);
        $display("job nt=2 acc=1 poked: lat=%0d clears=%0d sa=%b", lat, clr, sab[1:0]);
        chk("t6_latency", lat, 26);
        chk("t6_clears", clr, 2);
        chk("t6_shouldadd", sab[1:0], 2'b11);

        // Abort at count 8 of tile 1, then a clean job.
        @(posedge clk); #2;
        start = 1'b1; num_tiles = 8'd3; acc_en = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        begin
            int w;
            w = 0;
            while (!(tile_idx == 8'd1 && count == 5'd8) && w < 200) begin
                chk("t5_no_early_done", done, 0);
                @(posedge clk); #2;
                w++;
            end
            chk("t5_reached_abort_point", w < 200, 1);
        end
        rst_n = 1'b0;
        #1;
        chk("t5_async_clear", {busy, done, array_clear, feed_en, drain_valid, shouldAdd, count, tile_idx}, 0);
        @(posedge clk); #2;
        chk("t5_held_clear", {busy, done, count}, 0);
        rst_n = 1'b1;
        $display("abort during tile 1 count 8: outputs cleared");
        run_job(1, 1'b0, 0, 1'b0, lat, clr, drn, bsy, sab);
        $display("job after abort: lat=%0d clears=%0d sa=%b", lat, clr, sab[0]);
        chk("t5_restart_latency", lat, 13);
        chk("t5_restart_shouldadd", sab[0], 0);

        // Random traffic against the slot model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            stall     = ($urandom_range(0, 3) == 0);
            start     = ($urandom_range(0, 7) == 0);
            num_tiles = 8'($urandom_range(0, 3));
            acc_en    = 1'($urandom_range(0, 1));
            rst_n     = ($urandom_range(0, 599) != 0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1; start = 1'b0; stall = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
